// File: rtl/m_gen_date.sv
// m_gen_date: BCD calendar (day/month/year, 2000-2099) advanced by a synchronised day carry, with validated load
// clk, rst          : system clock, synchronous active-high reset
// clk_day           : asynchronous day carry, one advance per rising edge
// load, ld_*        : one-cycle request to load a BCD date {tens, units}
// day_*/mon_*/year_*: current BCD date digits
// clk_year          : one-cycle pulse after the 31-12-99 -> 01-01-00 wrap
// set_err           : one-cycle pulse when a load is rejected
module m_gen_date #(
  parameter logic [7:0] RST_DAY  = 8'h01,
  parameter logic [7:0] RST_MON  = 8'h01,
  parameter logic [7:0] RST_YEAR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_day,
  input  logic       load,
  input  logic [7:0] ld_day,
  input  logic [7:0] ld_mon,
  input  logic [7:0] ld_year,
  output logic [3:0] day_low,
  output logic [3:0] day_high,
  output logic [3:0] mon_low,
  output logic [3:0] mon_high,
  output logic [3:0] year_low,
  output logic [3:0] year_high,
  output logic       clk_year,
  output logic       set_err
);
  typedef enum logic [1:0] {IDLE, STEP, WRAP} state_t;

  state_t     state;
  logic [7:0] day, mon, year;
  logic [7:0] day_n, mon_n, year_n;
  logic       s1, s2, s3;
  logic       adv, last_day, last_mon, wrap, valid;

  function automatic logic leap(input logic [7:0] y);
    return y[4] ? (y[3:0] == 4'd2 || y[3:0] == 4'd6)
                : (y[3:0] == 4'd0 || y[3:0] == 4'd4 || y[3:0] == 4'd8);
  endfunction

  function automatic logic [7:0] dim(input logic [7:0] m, input logic [7:0] y);
    return m == 8'h02 ? (leap(y) ? 8'h29 : 8'h28) :
           (m == 8'h04 || m == 8'h06 || m == 8'h09 || m == 8'h11) ? 8'h30 : 8'h31;
  endfunction

  function automatic logic [7:0] inc(input logic [7:0] b);
    return b[3:0] == 4'd9 ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction

  assign adv      = s2 & ~s3;
  assign last_day = day == dim(mon, year);
  assign last_mon = mon == 8'h12;
  assign wrap     = last_day && last_mon && year == 8'h99;

  always_comb begin
    day_n  = last_day ? 8'h01 : inc(day);
    mon_n  = last_day ? (last_mon ? 8'h01 : inc(mon)) : mon;
    year_n = (last_day && last_mon) ? (wrap ? 8'h00 : inc(year)) : year;
    valid  = ld_day[7:4] <= 4'd9 && ld_day[3:0] <= 4'd9 &&
             ld_mon[7:4] <= 4'd9 && ld_mon[3:0] <= 4'd9 &&
             ld_year[7:4] <= 4'd9 && ld_year[3:0] <= 4'd9 &&
             ld_mon >= 8'h01 && ld_mon <= 8'h12 &&
             ld_day >= 8'h01 && ld_day <= dim(ld_mon, ld_year);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {s1, s2, s3} <= 3'b000;
      day          <= RST_DAY;
      mon          <= RST_MON;
      year         <= RST_YEAR;
      state        <= IDLE;
      set_err      <= 1'b0;
    end else begin
      {s1, s2, s3} <= {clk_day, s1, s2};
      set_err      <= load && !valid;
      state        <= (adv && !load) ? (wrap ? WRAP : STEP) : IDLE;
      if (load && valid) begin
        day  <= ld_day;
        mon  <= ld_mon;
        year <= ld_year;
      end else if (adv && !load) begin
        day  <= day_n;
        mon  <= mon_n;
        year <= year_n;
      end
    end
  end

  assign clk_year = state == WRAP;
  assign {day_high, day_low}   = day;
  assign {mon_high, mon_low}   = mon;
  assign {year_high, year_low} = year;
endmodule

// File: tb/tb_m_gen_date.sv
// tb_m_gen_date: directed self-checking bench for m_gen_date
module tb_m_gen_date;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_day = 1'b0;
  logic       load = 1'b0;
  logic [7:0] ld_day = 8'h00, ld_mon = 8'h00, ld_year = 8'h00;
  logic [3:0] day_low, day_high, mon_low, mon_high, year_low, year_high;
  logic       clk_year, set_err;
  logic [23:0] date;
  int checks = 0;
  int failures = 0;

  m_gen_date dut (
    .clk(clk), .rst(rst), .clk_day(clk_day), .load(load),
    .ld_day(ld_day), .ld_mon(ld_mon), .ld_year(ld_year),
    .day_low(day_low), .day_high(day_high), .mon_low(mon_low), .mon_high(mon_high),
    .year_low(year_low), .year_high(year_high), .clk_year(clk_year), .set_err(set_err)
  );

  always #5 clk = ~clk;
  assign date = {day_high, day_low, mon_high, mon_low, year_high, year_low};

  task automatic do_load(input logic [23:0] d, output logic e1, output logic e2);
    @(negedge clk);
    load = 1'b1;
    {ld_day, ld_mon, ld_year} = d;
    @(negedge clk);
    load = 1'b0;
    e1 = set_err;
    @(negedge clk);
    e2 = set_err;
  endtask

  task automatic pulse();
    @(negedge clk);
    clk_day = 1'b1;
    repeat (4) @(negedge clk);
    clk_day = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (date !== 24'h010100 || clk_year !== 1'b0 || set_err !== 1'b0) begin
      failures++;
      $display("FAIL reset: date=%h cy=%b err=%b want 010100 0 0", date, clk_year, set_err);
    end
    clk_day = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (date !== (i < 3 ? 24'h010100 : 24'h020100)) begin
        failures++;
        $display("FAIL long_carry cyc%0d: date=%h want %h", i, date, i < 3 ? 24'h010100 : 24'h020100);
      end
    end
    clk_day = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (date !== 24'h020100) begin
      failures++;
      $display("FAIL long_carry_after: date=%h want 020100", date);
    end
  endtask

  task automatic test_advance();
    logic        dl [11] = '{1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1};
    logic [23:0] ld [11] = '{24'h280223, 24'h280224, 24'h0, 24'h280200, 24'h300415, 24'h310115,
                             24'h090715, 24'h300915, 24'h0, 24'h300616, 24'h291103};
    logic [23:0] ex [11] = '{24'h010323, 24'h290224, 24'h010324, 24'h290200, 24'h010515, 24'h010215,
                             24'h100715, 24'h011015, 24'h021015, 24'h010716, 24'h301103};
    logic e1, e2;
    for (int i = 0; i < 11; i++) begin
      if (dl[i]) begin
        do_load(ld[i], e1, e2);
        checks++;
        if (date !== ld[i] || e1 !== 1'b0) begin
          failures++;
          $display("FAIL load%0d: date=%h err=%b want %h 0", i, date, e1, ld[i]);
        end
      end
      pulse();
      checks++;
      if (date !== ex[i] || clk_year !== 1'b0) begin
        failures++;
        $display("FAIL advance%0d: date=%h cy=%b want %h 0", i, date, clk_year, ex[i]);
      end
    end
  endtask

  task automatic test_year_wrap();
    logic [23:0] ld [2] = '{24'h311299, 24'h311245};
    logic [23:0] ex [2] = '{24'h010100, 24'h010146};
    logic [7:0]  pat [2] = '{8'b0000_1000, 8'b0000_0000};
    logic [7:0]  seen;
    logic e1, e2;
    for (int k = 0; k < 2; k++) begin
      do_load(ld[k], e1, e2);
      seen = 8'h00;
      @(negedge clk);
      clk_day = 1'b1;
      for (int i = 1; i < 8; i++) begin
        @(negedge clk);
        seen[i] = clk_year;
        if (i == 4) clk_day = 1'b0;
      end
      checks++;
      if (date !== ex[k] || seen !== pat[k]) begin
        failures++;
        $display("FAIL year_wrap%0d: date=%h cy_trace=%b want %h %b", k, date, seen, ex[k], pat[k]);
      end
    end
  endtask

  task automatic test_invalid_load();
    logic [23:0] bad [8] = '{24'h290223, 24'h310610, 24'h000510, 24'h101310,
                             24'h0A0510, 24'h100A10, 24'h10051A, 24'h320110};
    logic e1, e2;
    do_load(24'h120334, e1, e2);
    for (int i = 0; i < 8; i++) begin
      do_load(bad[i], e1, e2);
      checks++;
      if (date !== 24'h120334 || e1 !== 1'b1 || e2 !== 1'b0) begin
        failures++;
        $display("FAIL bad_load%0d: date=%h err=%b,%b want 120334 1,0", i, date, e1, e2);
      end
    end
  endtask

  task automatic test_load_vs_adv();
    logic e1, e2;
    do_load(24'h100320, e1, e2);
    @(negedge clk);
    clk_day = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b1;
    {ld_day, ld_mon, ld_year} = 24'h150820;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (date !== 24'h150820) begin
      failures++;
      $display("FAIL load_vs_adv: date=%h want 150820", date);
    end
    repeat (3) @(negedge clk);
    clk_day = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (date !== 24'h150820) begin
      failures++;
      $display("FAIL load_vs_adv_after: date=%h want 150820", date);
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    clk_day = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    clk_day = 1'b0;
    rst = 1'b0;
    checks++;
    if (date !== 24'h010100) begin
      failures++;
      $display("FAIL reset_inflight: date=%h want 010100", date);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (date !== 24'h010100 || clk_year !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_adv: date=%h cy=%b want 010100 0", date, clk_year);
    end
  endtask

  initial begin
    test_reset();
    test_advance();
    test_year_wrap();
    test_invalid_load();
    test_load_vs_adv();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/m_gen_date.md
Name: m_gen_date

Overview:
Calendar stage directly downstream of the hour generator. It consumes the once-per-day carry (clk_day) and keeps the date as BCD digits: day 01..31, month 01..12 and year 00..99, with 2000-2099 leap-year rules. It runs on the system clock, synchronises and edge-detects the day carry, and supports a validated parallel load for setting the date. The display mux reads its outputs.

Parameters:
RST_DAY, 8'h01, BCD day loaded on reset (high nibble = tens digit)
RST_MON, 8'h01, BCD month loaded on reset
RST_YEAR, 8'h00, BCD year loaded on reset

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
clk_day  input  1  day carry from the hour generator; asynchronous to clk, high for at least 3 clk periods
load  input  1  one-cycle request to load ld_* values
ld_day  input  8  BCD day {tens, units}
ld_mon  input  8  BCD month
ld_year  input  8  BCD year
day_low, day_high  output  4 each  BCD day digits
mon_low, mon_high  output  4 each  BCD month digits
year_low, year_high  output  4 each  BCD year digits
clk_year  output  1  one-cycle pulse when the date wraps from 31-12-99 to 01-01-00
set_err  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (rst=1 at a clk edge):
  - day/mon/year outputs take RST_*.
  - clk_year=0, set_err=0.
  - Synchroniser flops and the edge-detect flop are cleared to 0.
  - If reset is asserted mid-operation, a pending advance or load is discarded.
- Day-carry input path:
  - clk_day passes through a 2-flop synchroniser (s1, s2), then a history flop s3.
  - adv = s2 & ~s3.
  - The date is updated on the clk edge where adv=1, so outputs change 3 clk edges after clk_day is sampled high.
  - Exactly one advance occurs per clk_day rising edge, however long clk_day stays high.
- Days in month (dim):
  - Months 04, 06, 09, 11: 30.
  - Month 02: 29 if the year is a leap year, else 28.
  - All other months: 31.
- Leap year, evaluated directly on the BCD digits: (year_high even and year_low ∈ {0,4,8}) or (year_high odd and year_low ∈ {2,6}). Year 00 is a leap year.
- Advance, one step per adv:
  - day < dim: increment day in BCD (units 9 -> 0 with tens +1).
  - day == dim: day=01, then advance the month.
  - Month 12 wraps to 01 and advances the year.
  - Year 99 wraps to 00.
  - clk_year=1 for exactly the one cycle following the 31-12-99 -> 01-01-00 update; otherwise 0.
- Load:
  - Sampled on the edge where load=1.
  - Accepted only if all of the following hold:
    - Every nibble is ≤ 9.
    - Month is 01..12.
    - Day is 01..dim, with dim computed from ld_mon and ld_year.
  - Accepted: the outputs take the ld_* values on that edge.
  - Rejected: the date is unchanged and set_err=1 for one cycle.
- Simultaneous load and adv on the same edge: load wins and that advance is dropped, whether the load is accepted or rejected.
- Invariant: outputs never hold an invalid BCD date. Every reachable state satisfies the load-validation rule.
- Internal state decomposition:
  - Three digit-pair registers.
  - Small FSM: IDLE -> (adv) STEP -> IDLE, with the carry chain computed combinationally within a single cycle.
  - No multi-cycle ripple: all digits update on the same edge.

Test Plan:
1. Reset with default parameters -> outputs 01-01-00; clk_year=0; set_err=0. Hold clk_day high for 10 cycles -> exactly one advance to 02-01-00, visible 3 cycles after the rise.
2. Load 28-02-23 then pulse clk_day -> 01-03-23. Load 28-02-24 then pulse twice -> 29-02-24, then 01-03-24. Load 28-02-00 and pulse -> 29-02-00.
3. Load 30-04-15 and pulse -> 01-05-15. Load 31-01-15 and pulse -> 01-02-15. Load 09-07-15 and pulse -> 10-07-15 (BCD units carry).
4. Load 31-12-99 and pulse -> 01-01-00 with clk_year high for exactly 1 cycle. Load 31-12-45 and pulse -> 01-01-46 with clk_year staying 0.
5. Invalid loads: 29-02-23, 31-06-10, 00-05-10, 10-13-10, and nibble A in any field -> set_err pulses 1 cycle each and the date is unchanged.
6. Arrange a load of 15-08-20 on the same edge as adv -> result 15-08-20, not 16-08-20. Assert rst while a synchronised clk_day edge is in flight -> outputs go to 01-01-00 and no advance follows.
